// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg: RGB565 field widths, counter width default and receiver FSM states
package lcd_timing_pkg;
  localparam int R_W       = 5;
  localparam int G_W       = 6;
  localparam int B_W       = 5;
  localparam int PIX_W     = R_W + G_W + B_W;
  localparam int CNT_W_DEF = 11;
  typedef enum logic [1:0] {SEARCH, VBLANK, ACTIVE, HBLANK} lcd_state_e;
endpackage

// File: rtl/lcd_sat_counter.sv
// lcd_sat_counter: up-counter with synchronous clear (priority), enable and saturation at MAX
// Ports: PixelClk/nRST clock and async active-low reset; clr, en controls;
//   cnt registered count; nxt value cnt takes at the next edge.
module lcd_sat_counter #(
  parameter int W   = 11,
  parameter int MAX = 2**W - 1
) (
  input  logic         PixelClk,
  input  logic         nRST,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt
);
  localparam logic [W-1:0] TOP = W'(MAX);
  always_comb nxt = clr ? '0 : (en && cnt != TOP) ? cnt + W'(1) : cnt;
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) cnt <= '0;
    else cnt <= nxt;
endmodule

// File: rtl/lcd_de_rx.sv
// lcd_de_rx: DE-mode RGB565 panel stream receiver with pixel coordinates and frame timing lock
// Ports: PixelClk/nRST clock and async active-low reset; LCD_DE/LCD_R/LCD_G/LCD_B panel input;
//   pix_valid/pix_data/pix_x/pix_y/sof/eol pixel output, 2 cycles after input;
//   frame_width/frame_height size of the last completed frame; lock stable timing;
//   err one-cycle pulse at the eol of a line whose width differs from line 0.
module lcd_de_rx
  import lcd_timing_pkg::*;
#(
  parameter int VBLANK_MIN = 1200,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             PixelClk,
  input  logic             nRST,
  input  logic             LCD_DE,
  input  logic [R_W-1:0]   LCD_R,
  input  logic [G_W-1:0]   LCD_G,
  input  logic [B_W-1:0]   LCD_B,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sof,
  output logic             eol,
  output logic [CNT_W-1:0] frame_width,
  output logic [CNT_W-1:0] frame_height,
  output logic             lock,
  output logic             err
);
  localparam logic [CNT_W-1:0] VB_TOP = CNT_W'(VBLANK_MIN);
  lcd_state_e st, st_nxt;
  logic de1;
  logic [PIX_W-1:0] rgb1;
  logic [CNT_W-1:0] idle_unused, idle_nxt, x_nxt, y_nxt, ref_w, wid, hgt;
  logic reached, pix, start_frame, start_line, fend, eol_now, mismatch, bad;
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      de1  <= 1'b0;
      rgb1 <= '0;
    end else begin
      de1  <= LCD_DE;
      rgb1 <= {LCD_R, LCD_G, LCD_B};
    end
  // the idle count includes the current stage-1 sample, so reached can only be true while DE is low
  assign reached     = idle_nxt == VB_TOP;
  assign pix         = de1 && st != SEARCH;
  assign start_frame = de1 && st == VBLANK;
  assign start_line  = de1 && (st == VBLANK || st == HBLANK);
  assign fend        = reached && st == HBLANK;
  // the raw input is one sample ahead of stage 1, so it tells whether this pixel ends the line
  assign eol_now     = pix && !LCD_DE;
  assign wid         = &x_nxt ? x_nxt : x_nxt + CNT_W'(1);
  assign hgt         = &pix_y ? pix_y : pix_y + CNT_W'(1);
  assign mismatch    = eol_now && y_nxt != '0 && wid != ref_w;
  always_comb begin
    st_nxt = st;
    case (st)
      SEARCH:  st_nxt = reached ? VBLANK : SEARCH;
      VBLANK:  st_nxt = de1 ? ACTIVE : VBLANK;
      ACTIVE:  st_nxt = de1 ? ACTIVE : HBLANK;
      HBLANK:  st_nxt = de1 ? ACTIVE : reached ? VBLANK : HBLANK;
      default: st_nxt = SEARCH;
    endcase
  end
  lcd_sat_counter #(.W(CNT_W), .MAX(VBLANK_MIN)) u_idle (
    .PixelClk(PixelClk), .nRST(nRST), .clr(de1), .en(!de1), .cnt(idle_unused), .nxt(idle_nxt)
  );
  lcd_sat_counter #(.W(CNT_W)) u_pix (
    .PixelClk(PixelClk), .nRST(nRST), .clr(start_line), .en(pix), .cnt(pix_x), .nxt(x_nxt)
  );
  lcd_sat_counter #(.W(CNT_W)) u_line (
    .PixelClk(PixelClk), .nRST(nRST), .clr(start_frame), .en(start_line && st == HBLANK),
    .cnt(pix_y), .nxt(y_nxt)
  );
  always_ff @(posedge PixelClk or negedge nRST)
    if (!nRST) begin
      st           <= SEARCH;
      pix_valid    <= 1'b0;
      pix_data     <= '0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      err          <= 1'b0;
      bad          <= 1'b0;
      ref_w        <= '0;
      frame_width  <= '0;
      frame_height <= '0;
      lock         <= 1'b0;
    end else begin
      st        <= st_nxt;
      pix_valid <= pix;
      pix_data  <= rgb1;
      sof       <= start_frame;
      eol       <= eol_now;
      err       <= mismatch;
      bad       <= start_frame ? 1'b0 : bad | mismatch;
      if (eol_now && y_nxt == '0) ref_w <= wid;
      // zeroed size registers never match a real frame, so the first frame after reset cannot lock
      if (fend) begin
        frame_width  <= ref_w;
        frame_height <= hgt;
        lock         <= !bad && ref_w == frame_width && hgt == frame_height;
      end
    end
endmodule

// File: tb/tb_lcd_de_rx.sv
// tb_lcd_de_rx: scoreboard bench for lcd_de_rx on a scaled-down panel timing
module tb_lcd_de_rx;
  localparam int VBM = 12;
  localparam int W   = 8;
  localparam int H   = 12;
  localparam int HB  = 5;
  localparam int VBG = HB + 3 * (W + HB);
  typedef struct packed {
    logic [31:0] t;
    logic [15:0] d;
    logic [10:0] x;
    logic [10:0] y;
    logic        sof;
    logic        eol;
    logic        err;
  } exp_t;
  logic        PixelClk = 1'b0;
  logic        nRST = 1'b0;
  logic        LCD_DE = 1'b0;
  logic [4:0]  LCD_R = '0;
  logic [5:0]  LCD_G = '0;
  logic [4:0]  LCD_B = '0;
  logic        pix_valid, sof, eol, lock, err;
  logic [15:0] pix_data;
  logic [10:0] pix_x, pix_y, frame_width, frame_height;
  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  lcd_de_rx #(.VBLANK_MIN(VBM), .CNT_W(11)) dut (
    .PixelClk(PixelClk), .nRST(nRST), .LCD_DE(LCD_DE), .LCD_R(LCD_R), .LCD_G(LCD_G), .LCD_B(LCD_B),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .sof(sof), .eol(eol),
    .frame_width(frame_width), .frame_height(frame_height), .lock(lock), .err(err)
  );
  always #5 PixelClk = ~PixelClk;
  always @(posedge PixelClk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic monitor();
    exp_t e, a;
    forever begin
      @(negedge PixelClk);
      if (nRST) begin
        if (pix_valid) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_pixel: cycle %0d x=%0d y=%0d sof=%b", cyc, pix_x, pix_y, sof);
          end else begin
            e = sb.pop_front();
            a = '{t: cyc, d: pix_data, x: pix_x, y: pix_y, sof: sof, eol: eol, err: err};
            if (a !== e)
              begin
                n_bad++;
                $display("FAIL pixel: got t=%0d d=%h x=%0d y=%0d sof=%b eol=%b err=%b want t=%0d d=%h x=%0d y=%0d sof=%b eol=%b err=%b",
                         a.t, a.d, a.x, a.y, a.sof, a.eol, a.err, e.t, e.d, e.x, e.y, e.sof, e.eol, e.err);
              end
          end
        end else if (err) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stray_err: err=1 without pixel at cycle %0d, want 0", cyc);
        end
      end
    end
  endtask
  task automatic drive(input bit de, input bit trk, input int x, input int y, input bit last, input bit e);
    logic [15:0] rgb;
    @(negedge PixelClk);
    rgb = (x == 0 && y == 0) ? 16'hF801 : 16'(x * 37 + y * 101 + 7);
    LCD_DE = de;
    {LCD_R, LCD_G, LCD_B} = de ? rgb : 16'h0;
    if (de && trk)
      sb.push_back('{t: cyc + 2, d: rgb, x: x[10:0], y: y[10:0], sof: x == 0 && y == 0, eol: last, err: e});
  endtask
  task automatic blank(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask
  task automatic line(input int y, input int w, input bit trk, input bit e, input bit tail);
    for (int x = 0; x < w; x++) drive(1'b1, trk, x, y, x == w - 1, e && x == w - 1);
    if (tail) blank(HB);
  endtask
  task automatic frame(input int y0, input int y1, input bit trk, input int bad_y, input bit vb);
    for (int y = y0; y < y1; y++) line(y, y == bad_y ? W - 1 : W, trk, y == bad_y, 1'b1);
    if (vb) blank(VBG - HB);
  endtask
  task automatic fchk(input string nm, input int fw, input int fh, input bit lk);
    chk({nm, "_width"}, 80'(frame_width), 80'(fw));
    chk({nm, "_height"}, 80'(frame_height), 80'(fh));
    chk({nm, "_lock"}, 80'(lock), 80'(lk));
  endtask
  initial begin
    fork
      monitor();
    join_none
    repeat (3) @(negedge PixelClk);
    chk("reset_outputs", 80'({pix_valid, pix_data, pix_x, pix_y, sof, eol, frame_width, frame_height, lock, err}), 80'h0);
    nRST = 1'b1;
    blank(3);
    frame(5, H, 1'b0, -1, 1'b1);
    frame(0, H, 1'b1, -1, 1'b1);
    fchk("frame1", W, H, 1'b0);
    frame(0, H, 1'b1, -1, 1'b1);
    fchk("frame2", W, H, 1'b1);
    frame(0, H, 1'b1, -1, 1'b1);
    fchk("frame3", W, H, 1'b1);
    frame(0, H, 1'b1, 10, 1'b1);
    fchk("bad_frame", W, H, 1'b0);
    frame(0, H, 1'b1, -1, 1'b1);
    frame(0, H, 1'b1, -1, 1'b1);
    fchk("relock", W, H, 1'b1);
    frame(0, 5, 1'b1, -1, 1'b0);
    line(5, 4, 1'b1, 1'b0, 1'b0);
    #2 nRST = 1'b0;
    #1 chk("async_reset", 80'({pix_valid, pix_data, pix_x, pix_y, sof, eol, frame_width, frame_height, lock, err}), 80'h0);
    sb.delete();
    blank(3);
    nRST = 1'b1;
    frame(6, H, 1'b0, -1, 1'b1);
    frame(0, H, 1'b1, -1, 1'b1);
    fchk("after_reset", W, H, 1'b0);
    line(0, 1, 1'b1, 1'b0, 1'b1);
    blank(VBG);
    fchk("pulse", 1, 1, 1'b0);
    blank(5);
    chk("scoreboard_empty", 80'(sb.size()), 80'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_de_rx.md
LCD_DE_RX -- requirements
Module: lcd_de_rx

Interface
REQ-001 The block SHALL use parameter VBLANK_MIN, default 1200, meaning the consecutive DE-low cycles that mark vertical blank (must exceed the longest horizontal blank).
REQ-002 The block SHALL use parameter CNT_W, default 11, meaning the width of the coordinate and measurement counters.
REQ-003 PixelClk  in  1  pixel clock; the only clock; all logic updates on the rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 LCD_DE  in  1  data-enable from the DE-mode RGB panel stream.
REQ-006 LCD_R / LCD_G / LCD_B  in  5/6/5  RGB565 pixel components.
REQ-007 pix_valid  out  1  pixel strobe for pix_data, pix_x and pix_y.
REQ-008 pix_data  out  16  packed {R,G,B}, with R in [15:11], G in [10:5] and B in [4:0].
REQ-009 pix_x / pix_y  out  CNT_W each  pixel column and line index within the frame.
REQ-010 sof / eol  out  1 each  start-of-frame and end-of-line flags, qualified by pix_valid.
REQ-011 frame_width / frame_height  out  CNT_W each  measured active width and line count of the last completed frame.
REQ-012 lock  out  1  stream timing is stable.
REQ-013 err  out  1  one-cycle pulse on a line-width mismatch.

Function
REQ-014 Inputs SHALL be registered once (stage 1); outputs SHALL be registered (stage 2); pixel latency SHALL be exactly 2 PixelClk cycles from input to pix_valid.
REQ-015 The FSM SHALL have the states SEARCH, VBLANK, ACTIVE and HBLANK.
REQ-016 SEARCH SHALL be entered from reset and SHALL go to VBLANK when the idle counter reaches VBLANK_MIN; pixels SHALL be discarded in SEARCH (pix_valid=0).
REQ-017 VBLANK SHALL go to ACTIVE on DE rising; that line SHALL be line 0.
REQ-018 ACTIVE SHALL go to HBLANK on DE falling.
REQ-019 HBLANK SHALL go to ACTIVE on DE rising, incrementing the line index.
REQ-020 HBLANK SHALL go to VBLANK, with a frame-end event, when the idle counter reaches VBLANK_MIN.
REQ-021 The idle counter SHALL count consecutive DE-low cycles, clear on DE high, and saturate at VBLANK_MIN; at most one frame-end event SHALL occur per blank interval.
REQ-022 pix_x SHALL be 0 on the first pixel of each line and increment by 1 per valid pixel, saturating at 2^CNT_W-1.
REQ-023 pix_y SHALL be 0 on the first line after VBLANK, saturating likewise.
REQ-024 sof SHALL be 1 only with the pixel at (0,0) of a frame entered from VBLANK.
REQ-025 eol SHALL be 1 with the last valid pixel of each line, detected from stage-1 DE=1 and the new DE sample=0.
REQ-026 A DE pulse one cycle long SHALL produce a single pixel with sof/eol as applicable and a width of 1.
REQ-027 The width of line 0 SHALL be the frame reference width.
REQ-028 Any later line of a different width SHALL pulse err for 1 cycle, coincident with that line's eol, and SHALL mark the frame bad.
REQ-029 On frame-end, frame_width SHALL be loaded with the reference width and frame_height with the line count, both in the same cycle.
REQ-030 On frame-end, lock SHALL be set if width and height equal the previous frame's and the frame is not bad; otherwise lock SHALL be cleared.
REQ-031 lock SHALL change only on frame-end.
REQ-032 The first frame-end after reset SHALL never set lock.
REQ-033 DE high with no valid vblank seen SHALL produce no outputs and no measurement updates.

Reset
REQ-034 On nRST low, all outputs SHALL be 0 immediately, the FSM SHALL go to SEARCH, and all counters and stored previous-frame values SHALL be cleared.
REQ-035 Reset mid-frame SHALL abandon the frame; after release the block SHALL re-acquire via SEARCH.

Structure
REQ-036 Shared package lcd_timing_pkg SHALL hold the RGB565 field widths (5/6/5), CNT_W default and the FSM state enum.
REQ-037 One sub-module SHALL be used: lcd_sat_counter (clear, enable, saturating), instantiated for the idle, pixel and line counters.

Verification
REQ-038 Bench SHALL drive 3 frames of 800x480, with H blank 392 and V blank 45 lines (1192-cycle lines) -> frame_width=800, frame_height=480 after frame 1; lock=1 after frame 2; err never set.
REQ-039 Bench SHALL drive a DE stream starting mid-frame after reset -> no pix_valid until the first 1200-cycle low gap; first output has sof=1, pix_x=0, pix_y=0.
REQ-040 Bench SHALL drive line 10 of a locked frame at 799 pixels -> err pulse at its eol; lock=0 at that frame-end; lock=1 again after 2 further clean frames.
REQ-041 Bench SHALL drive input R=5'h1F, G=0, B=5'h01 -> pix_data=16'hF801, 2 cycles later.
REQ-042 Bench SHALL drive a 1-cycle DE pulse after vblank followed by blank -> one pixel with sof=1 and eol=1, then frame_width=1 and frame_height=1.
REQ-043 Bench SHALL assert nRST at line 200, pixel 300 -> all outputs 0 asynchronously; no sof until the next full vblank.
